fir_stream_arbiter: RTL and testbench

Frame-level arbiter and configurator in front of the 9-tap symmetric FIR stream filter. Shares the filter's single AXI4-Stream byte input between two requester channels, round-robin at frame (tlast) boundaries. Before granting a channel whose coefficients are not currently loaded, it reprograms the filter's coefficient registers over the filter's APB slave port. Sits between the two sample sources and the FIR input/APB ports; the FIR output is untouched.

---
 rtl/fir_stream_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_fir_stream_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_stream_arbiter.sv
// Frame-level round-robin arbiter in front of the 9-tap FIR: reprograms the FIR
// coefficients over APB when needed. FIR_ARB_FLUSH_EN adds zero-beat tail flushing.
module fir_stream_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  s0_tdata,
  input  logic        s0_tvalid,
  input  logic        s0_tlast,
  output logic        s0_tready,
  input  logic [7:0]  s1_tdata,
  input  logic        s1_tvalid,
  input  logic        s1_tlast,
  output logic        s1_tready,
  input  logic [31:0] ch0_coef_lo,
  input  logic [7:0]  ch0_coef_hi,
  input  logic [31:0] ch1_coef_lo,
  input  logic [7:0]  ch1_coef_hi,
  input  logic        cfg_reload,
  output logic [7:0]  m_tdata,
  output logic        m_tvalid,
  output logic        m_tlast,
  input  logic        m_tready,
  output logic [3:0]  apb_paddr,
  output logic        apb_psel,
  output logic        apb_penable,
  output logic        apb_pwrite,
  output logic [31:0] apb_pwdata,
  input  logic        apb_pready,
  output logic        grant_ch,
  output logic        busy,
  output logic [2:0]  o_dbg_state
);

  localparam logic [3:0] COEF_LO_ADDR = 4'h8;
  localparam logic [3:0] COEF_HI_ADDR = 4'hC;

  typedef enum logic [2:0] {
    S_IDLE          = 3'd0,
    S_CFG_LO_SETUP  = 3'd1,
    S_CFG_LO_ACCESS = 3'd2,
    S_CFG_HI_SETUP  = 3'd3,
    S_CFG_HI_ACCESS = 3'd4,
`ifdef FIR_ARB_FLUSH_EN
    S_STREAM        = 3'd5,
    S_FLUSH         = 3'd6
`else
    S_STREAM        = 3'd5
`endif
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic r_grant;
  logic r_last_grant;
  logic r_loaded_ch;
  logic r_loaded_valid;
  logic r_dirty;

  logic        w_any_valid;
  logic        w_pick;
  logic        w_need_reload;
  logic [7:0]  w_sel_data;
  logic        w_sel_valid;
  logic        w_sel_last;
  logic [31:0] w_coef_lo;
  logic [7:0]  w_coef_hi;
  logic        w_cfg_done;

  // Handshake: a beat moves on a cycle where valid and ready are both high;
  // valid never waits on ready, and the stream path is purely combinational.
  assign w_any_valid = s0_tvalid | s1_tvalid;
  // Both requesting: the channel that did not win last time goes next.
  assign w_pick      = (s0_tvalid & s1_tvalid) ? ~r_last_grant : s1_tvalid;
  assign w_need_reload = ~r_loaded_valid | (r_loaded_ch != w_pick) | r_dirty;

  assign w_sel_data  = r_grant ? s1_tdata  : s0_tdata;
  assign w_sel_valid = r_grant ? s1_tvalid : s0_tvalid;
  assign w_sel_last  = r_grant ? s1_tlast  : s0_tlast;
  assign w_coef_lo   = r_grant ? ch1_coef_lo : ch0_coef_lo;
  assign w_coef_hi   = r_grant ? ch1_coef_hi : ch0_coef_hi;
  assign w_cfg_done  = (r_state == S_CFG_HI_ACCESS) && apb_pready;

  assign grant_ch    = r_grant;
  assign busy        = (r_state != S_IDLE);
  assign o_dbg_state = r_state;

`ifdef FIR_ARB_FLUSH_EN
  localparam int FLUSH_BEATS = 8;
  localparam int FCW = $clog2(FLUSH_BEATS + 1);
  logic [FCW-1:0] r_flush_cnt;
  logic           w_flush_last;

  assign w_flush_last = m_tready && (r_flush_cnt == FCW'(FLUSH_BEATS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_flush_cnt <= '0;
    end else if (r_state != S_FLUSH) begin
      r_flush_cnt <= '0;
    end else if (m_tready) begin
      r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_grant        <= 1'b0;
      r_last_grant   <= 1'b1;
      r_loaded_ch    <= 1'b0;
      r_loaded_valid <= 1'b0;
      r_dirty        <= 1'b0;
    end else begin
      if (r_state == S_IDLE && w_any_valid) begin
        r_grant      <= w_pick;
        r_last_grant <= w_pick;
      end
      if (w_cfg_done) begin
        r_loaded_ch    <= r_grant;
        r_loaded_valid <= 1'b1;
      end
      // A reload request arriving on the completing cycle must survive.
      if (cfg_reload) begin
        r_dirty <= 1'b1;
      end else if (w_cfg_done) begin
        r_dirty <= 1'b0;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    m_tdata     = 8'h00;
    m_tvalid    = 1'b0;
    m_tlast     = 1'b0;
    s0_tready   = 1'b0;
    s1_tready   = 1'b0;
    apb_paddr   = 4'h0;
    apb_psel    = 1'b0;
    apb_penable = 1'b0;
    apb_pwrite  = 1'b0;
    apb_pwdata  = 32'h0;
    case (r_state)
      S_IDLE: begin
        if (w_any_valid) begin
          w_state_nxt = w_need_reload ? S_CFG_LO_SETUP : S_STREAM;
        end
      end
      S_CFG_LO_SETUP, S_CFG_LO_ACCESS: begin
        apb_psel    = 1'b1;
        apb_pwrite  = 1'b1;
        apb_paddr   = COEF_LO_ADDR;
        apb_pwdata  = w_coef_lo;
        apb_penable = (r_state == S_CFG_LO_ACCESS);
        if (r_state == S_CFG_LO_SETUP) begin
          w_state_nxt = S_CFG_LO_ACCESS;
        end else if (apb_pready) begin
          w_state_nxt = S_CFG_HI_SETUP;
        end
      end
      S_CFG_HI_SETUP, S_CFG_HI_ACCESS: begin
        apb_psel    = 1'b1;
        apb_pwrite  = 1'b1;
        apb_paddr   = COEF_HI_ADDR;
        apb_pwdata  = {24'h0, w_coef_hi};
        apb_penable = (r_state == S_CFG_HI_ACCESS);
        if (r_state == S_CFG_HI_SETUP) begin
          w_state_nxt = S_CFG_HI_ACCESS;
        end else if (apb_pready) begin
          w_state_nxt = S_STREAM;
        end
      end
      S_STREAM: begin
        m_tdata   = w_sel_data;
        m_tvalid  = w_sel_valid;
        m_tlast   = w_sel_last;
        s0_tready = ~r_grant & m_tready;
        s1_tready = r_grant & m_tready;
        if (w_sel_valid && m_tready && w_sel_last) begin
`ifdef FIR_ARB_FLUSH_EN
          w_state_nxt = S_FLUSH;
`else
          w_state_nxt = S_IDLE;
`endif
        end
      end
`ifdef FIR_ARB_FLUSH_EN
      // Zero beats drain the FIR delay line so the next frame starts clean.
      S_FLUSH: begin
        m_tvalid = 1'b1;
        if (w_flush_last) begin
          w_state_nxt = S_IDLE;
        end
      end
`endif
      default: w_state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_fir_stream_arbiter.sv
// Directed bench for fir_stream_arbiter: scoreboard queues for stream beats and
// APB writes, popped by monitors; latency and reset checks in the main sequence.
module tb_fir_stream_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  s0_tdata, s1_tdata;
  logic        s0_tvalid, s1_tvalid, s0_tlast, s1_tlast;
  logic        s0_tready, s1_tready;
  logic [31:0] ch0_coef_lo, ch1_coef_lo;
  logic [7:0]  ch0_coef_hi, ch1_coef_hi;
  logic        cfg_reload;
  logic [7:0]  m_tdata;
  logic        m_tvalid, m_tlast, m_tready;
  logic [3:0]  apb_paddr;
  logic        apb_psel, apb_penable, apb_pwrite, apb_pready;
  logic [31:0] apb_pwdata;
  logic        grant_ch, busy;
  logic [2:0]  dbg_state;

  int tests = 0;
  int fails = 0;
  logic [9:0]  exp_q[$];
  logic [35:0] apb_q[$];
  logic        frame_done;

  fir_stream_arbiter dut (
    .clk(clk), .rst(rst),
    .s0_tdata(s0_tdata), .s0_tvalid(s0_tvalid), .s0_tlast(s0_tlast), .s0_tready(s0_tready),
    .s1_tdata(s1_tdata), .s1_tvalid(s1_tvalid), .s1_tlast(s1_tlast), .s1_tready(s1_tready),
    .ch0_coef_lo(ch0_coef_lo), .ch0_coef_hi(ch0_coef_hi),
    .ch1_coef_lo(ch1_coef_lo), .ch1_coef_hi(ch1_coef_hi),
    .cfg_reload(cfg_reload),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
    .apb_paddr(apb_paddr), .apb_psel(apb_psel), .apb_penable(apb_penable),
    .apb_pwrite(apb_pwrite), .apb_pwdata(apb_pwdata), .apb_pready(apb_pready),
    .grant_ch(grant_ch), .busy(busy), .o_dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    tests++;
    fails++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // expectation builders
  task automatic exp_frame(input int ch, input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({ch[0], (i == n - 1), base + 8'(i)});
    end
`ifdef FIR_ARB_FLUSH_EN
    for (int i = 0; i < 8; i++) exp_q.push_back({ch[0], 1'b0, 8'h00});
`endif
  endtask

  task automatic exp_cfg(input int ch);
    apb_q.push_back({4'h8, (ch == 0) ? ch0_coef_lo : ch1_coef_lo});
    apb_q.push_back({4'hC, 24'h0, (ch == 0) ? ch0_coef_hi : ch1_coef_hi});
  endtask

  // drivers
  task automatic drive_beat(input int ch, input logic [7:0] d, input logic l);
    int n = 0;
    if (ch == 0) begin
      s0_tdata = d; s0_tlast = l; s0_tvalid = 1'b1;
    end else begin
      s1_tdata = d; s1_tlast = l; s1_tvalid = 1'b1;
    end
    do begin
      @(negedge clk);
      n++;
    end while (!((ch == 0) ? s0_tready : s1_tready) && n < 300);
    if (n >= 300) timeout("beat_handshake");
    @(posedge clk);
    #1;
    if (ch == 0) s0_tvalid = 1'b0;
    else         s1_tvalid = 1'b0;
  endtask

  task automatic send_frame(input int ch, input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) drive_beat(ch, base + 8'(i), (i == n - 1));
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 500);
    if (n >= 500) timeout("wait_idle");
    @(posedge clk);
    #1;
  endtask

  task automatic measure(input string name, input int exp_lat);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!m_tvalid && n < 100);
    check(name, n - 1, exp_lat);
  endtask

  // scoreboard monitors
  always @(negedge clk) begin
    if (!rst && m_tvalid) begin
      check("idle_ch_tready", grant_ch ? s0_tready : s1_tready, 0);
      if (m_tready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", {grant_ch, m_tlast, m_tdata}, 10'h3FF);
        end else begin
          check("stream_beat", {grant_ch, m_tlast, m_tdata}, exp_q.pop_front());
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && apb_psel && apb_penable && apb_pready) begin
      check("apb_pwrite", apb_pwrite, 1);
      if (apb_q.size() == 0) begin
        check("unexpected_apb", {apb_paddr, apb_pwdata}, 36'hFFFFFFFFF);
      end else begin
        check("apb_write", {apb_paddr, apb_pwdata}, apb_q.pop_front());
      end
    end
  end

  initial begin
    rst = 1'b1;
    s0_tdata = 0; s0_tvalid = 0; s0_tlast = 0;
    s1_tdata = 0; s1_tvalid = 0; s1_tlast = 0;
    ch0_coef_lo = 32'h775F3F1C; ch0_coef_hi = 8'h7F;
    ch1_coef_lo = 32'h11223344; ch1_coef_hi = 8'h55;
    cfg_reload = 0; m_tready = 1; apb_pready = 1; frame_done = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_m_tvalid", m_tvalid, 0);
    check("rst_m_tdata", m_tdata, 0);
    check("rst_m_tlast", m_tlast, 0);
    check("rst_tready", {s0_tready, s1_tready}, 0);
    check("rst_apb", {apb_psel, apb_penable, apb_pwrite, apb_paddr, apb_pwdata}, 0);
    check("rst_busy_grant", {busy, grant_ch}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // first channel-0 frame: full reload then 4 beats
    exp_cfg(0);
    exp_frame(0, 8'h10, 4);
    fork
      send_frame(0, 8'h10, 4);
      measure("lat_first_reload", 5);
    join
    wait_idle();

    // second channel-0 frame: already loaded
    exp_frame(0, 8'hF0, 2);
    fork
      send_frame(0, 8'hF0, 2);
      measure("lat_no_reload", 1);
    join
    wait_idle();

    // both channels busy: 0,1,0,1 with reload on each switch
    exp_frame(0, 8'h20, 3);
    exp_cfg(1);
    exp_frame(1, 8'h30, 3);
    exp_cfg(0);
    exp_frame(0, 8'h40, 3);
    exp_cfg(1);
    exp_frame(1, 8'h50, 3);
    fork
      begin
        send_frame(0, 8'h20, 3);
        send_frame(0, 8'h40, 3);
      end
      begin
        @(posedge clk);
        #1;
        send_frame(1, 8'h30, 3);
        send_frame(1, 8'h50, 3);
      end
    join
    wait_idle();

    // pready stall in CFG_HI_ACCESS plus m_tready toggling
    exp_cfg(0);
    exp_frame(0, 8'h60, 4);
    frame_done = 0;
    fork
      begin
        send_frame(0, 8'h60, 4);
        frame_done = 1;
      end
      measure("lat_pready_stall", 8);
      begin
        int n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!(apb_psel && !apb_penable && apb_paddr == 4'hC) && n < 100);
        if (n >= 100) timeout("hi_setup");
        apb_pready = 1'b0;
        repeat (3) begin
          @(posedge clk);
          @(negedge clk);
          check("stall_ctrl", {apb_psel, apb_penable, apb_pwrite, apb_paddr}, {3'b111, 4'hC});
          check("stall_pwdata", apb_pwdata, {24'h0, ch0_coef_hi});
        end
        @(posedge clk);
        #1;
        apb_pready = 1'b1;
      end
      begin
        while (!frame_done) begin
          @(posedge clk);
          #1;
          m_tready = ~m_tready;
        end
        m_tready = 1'b1;
      end
    join
    wait_idle();

    // cfg_reload mid-frame: frame unchanged, next grant reprograms
    exp_frame(0, 8'h70, 4);
    fork
      send_frame(0, 8'h70, 4);
      measure("lat_before_reload", 1);
      begin
        repeat (2) @(posedge clk);
        #1;
        cfg_reload = 1'b1;
        @(posedge clk);
        #1;
        cfg_reload = 1'b0;
      end
    join
    wait_idle();
    ch0_coef_lo = 32'hA1B2C3D4;
    ch0_coef_hi = 8'h0E;
    exp_cfg(0);
    exp_frame(0, 8'h80, 2);
    fork
      send_frame(0, 8'h80, 2);
      measure("lat_dirty_reload", 5);
    join
    wait_idle();

    // reset during CFG_LO_ACCESS
    cfg_reload = 1'b1;
    @(posedge clk);
    #1;
    cfg_reload = 1'b0;
    apb_pready = 1'b0;
    s0_tdata = 8'hEE; s0_tlast = 1'b0; s0_tvalid = 1'b1;
    begin
      int n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!(apb_psel && apb_penable) && n < 50);
      if (n >= 50) timeout("lo_access");
    end
    check("lo_access_addr", apb_paddr, 4'h8);
    rst = 1'b1;
    #1;
    check("rst_mid_apb", {apb_psel, apb_penable, apb_pwrite}, 0);
    check("rst_mid_busy", {busy, m_tvalid}, 0);
    s0_tvalid = 1'b0;
    apb_pready = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    exp_cfg(0);
    exp_frame(0, 8'h90, 3);
    fork
      send_frame(0, 8'h90, 3);
      measure("lat_after_reset", 5);
    join
    wait_idle();

    check("stream_q_empty", exp_q.size(), 0);
    check("apb_q_empty", apb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
